// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD display controller: FSM encoding,
// digit count, seven-segment patterns and the double-dabble adjust helper.
package bcd_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int NUM_DIGITS = 3;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] digit_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Double-dabble correction applied before each shift
  function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
    logic [3:0] res;
    if (digit >= 4'd5) begin
      res = digit + 4'd3;
    end else begin
      res = digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_display_ctrl_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking;
// the parent registers the result.
module seg7_decode
  import bcd_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup, forced dark when blanked
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = digit_pattern(digit);
    end
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one shift per clock)
// with a three-digit multiplexed common-anode scanner.
// Optional macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_display_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       bcd_valid,
  output logic [3:0] cen,
  output logic [3:0] dec,
  output logic [3:0] uni,
  output logic [2:0] an,
  output logic [6:0] seg
);

  logic [1:0]  state_r, state_s;
  logic [7:0]  shreg_r;
  logic [3:0]  wcen_r, wdec_r, wuni_r;
  logic [2:0]  cnt_r;
  logic [3:0]  cen_r, dec_r, uni_r;
  logic        in_ready_r, busy_r, bcd_valid_r;
  logic [3:0]  adj_cen_s, adj_dec_s, adj_uni_s;
  logic [3:0]  sh_cen_s, sh_dec_s, sh_uni_s;
  logic [7:0]  sh_reg_s;
  logic        unused_cen_msb_s;

  logic [SCAN_DIV-1:0] scan_cnt_r;
  logic [1:0]  idx_r, idx_s;
  logic [2:0]  an_r, an_s;
  logic [6:0]  seg_r, dec_seg_s;
  logic [3:0]  sel_digit_s;
  logic        sel_blank_s;
  logic        wrap_s;

  // Next-state logic of the conversion FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == 3'd0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // One double-dabble step: correct each digit, then shift the whole chain left
  always_comb begin
    adj_cen_s = dd_adjust(wcen_r);
    adj_dec_s = dd_adjust(wdec_r);
    adj_uni_s = dd_adjust(wuni_r);
    sh_cen_s  = {adj_cen_s[2:0], adj_dec_s[3]};
    sh_dec_s  = {adj_dec_s[2:0], adj_uni_s[3]};
    sh_uni_s  = {adj_uni_s[2:0], shreg_r[7]};
    sh_reg_s  = {shreg_r[6:0], 1'b0};
  end

  // The hundreds digit stays below 5, so its carry-out is always zero
  assign unused_cen_msb_s = adj_cen_s[3];

  // FSM state register and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      bcd_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      bcd_valid_r <= (state_s == ST_DONE);
    end
  end

  // Conversion datapath; result registers only load on the final shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= 8'd0;
      wcen_r  <= 4'd0;
      wdec_r  <= 4'd0;
      wuni_r  <= 4'd0;
      cnt_r   <= 3'd0;
      cen_r   <= 4'd0;
      dec_r   <= 4'd0;
      uni_r   <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            shreg_r <= in_data;
            wcen_r  <= 4'd0;
            wdec_r  <= 4'd0;
            wuni_r  <= 4'd0;
            cnt_r   <= 3'd7;
          end
        end
        ST_SHIFT: begin
          shreg_r <= sh_reg_s;
          wcen_r  <= sh_cen_s;
          wdec_r  <= sh_dec_s;
          wuni_r  <= sh_uni_s;
          if (cnt_r == 3'd0) begin
            cen_r <= sh_cen_s;
            dec_r <= sh_dec_s;
            uni_r <= sh_uni_s;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= 3'd0;
        end
      endcase
    end
  end

  assign wrap_s = &scan_cnt_r;

  // Index the scanner moves to on the next wrap, its anode pattern and digit
  always_comb begin
    idx_s       = 2'd0;
    an_s        = 3'b111;
    sel_digit_s = uni_r;
    sel_blank_s = 1'b0;
    if (idx_r == 2'd2) begin
      idx_s = 2'd0;
    end else begin
      idx_s = idx_r + 2'd1;
    end
    case (idx_s)
      2'd0: begin
        an_s        = 3'b110;
        sel_digit_s = uni_r;
      end
      2'd1: begin
        an_s        = 3'b101;
        sel_digit_s = dec_r;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        sel_blank_s = (cen_r == 4'd0) && (dec_r == 4'd0);
`else
        sel_blank_s = 1'b0;
`endif
      end
      2'd2: begin
        an_s        = 3'b011;
        sel_digit_s = cen_r;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        sel_blank_s = (cen_r == 4'd0);
`else
        sel_blank_s = 1'b0;
`endif
      end
      default: begin
        an_s        = 3'b111;
        sel_digit_s = uni_r;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (sel_digit_s),
    .blank (sel_blank_s),
    .seg   (dec_seg_s)
  );

  // Refresh prescaler and registered anode/segment drive, both updated on wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
      idx_r      <= 2'd2;
      an_r       <= 3'b111;
      seg_r      <= SEG_BLANK;
    end else begin
      scan_cnt_r <= scan_cnt_r + {{(SCAN_DIV-1){1'b0}}, 1'b1};
      if (wrap_s) begin
        idx_r <= idx_s;
        an_r  <= an_s;
        seg_r <= dec_seg_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign bcd_valid = bcd_valid_r;
  assign cen       = cen_r;
  assign dec       = dec_r;
  assign uni       = uni_r;
  assign an        = an_r;
  assign seg       = seg_r;

endmodule
